// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: ALU control codes and FSM states.
package alu_share_arbiter_pkg;

    localparam logic [3:0] AluAnd   = 4'b0000;
    localparam logic [3:0] AluOr    = 4'b0001;
    localparam logic [3:0] AluAdd   = 4'b0010;
    localparam logic [3:0] AluSub   = 4'b0110;
    localparam logic [3:0] AluSlt   = 4'b0111;
    localparam logic [3:0] AluNoteq = 4'b1000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational ALU shared by both requesters. Unknown control codes pass operand A
// through and report zero=0.
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        ctrl,
    output logic [DATA_W-1:0] alu_out,
    output logic              zero
);

    logic known;

    always_comb begin
        alu_out = a;
        known   = 1'b1;
        case (ctrl)
            AluAnd:   alu_out = a & b;
            AluOr:    alu_out = a | b;
            AluAdd:   alu_out = a + b;
            AluSub:   alu_out = a - b;
            AluSlt:   alu_out = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            AluNoteq: alu_out = {{(DATA_W-1){1'b0}}, (a != b)};
            default: begin
                alu_out = a;
                known   = 1'b0;
            end
        endcase
        zero = known && (alu_out == '0);
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one operation in flight,
// IDLE -> EXEC -> RESP per operation.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_ctrl,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              last_grant_q;
    logic [DATA_W-1:0] op_a_q, op_b_q;
    logic [3:0]        op_ctrl_q;
    logic              op_id_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_result_q;
    logic              rsp_zero_q;

    logic              idle_open;
    logic              grant_any;
    logic              grant_id;
    logic              accept;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        idle_open  = (state_q == StIdle) && !rst;
        grant_any  = req0_valid || req1_valid;
        grant_id   = (req0_valid && req1_valid) ? !last_grant_q : req1_valid;
        accept     = idle_open && grant_any;
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_ctrl_q    <= '0;
            op_id_q      <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= grant_id;
                op_a_q       <= grant_id ? req1_a : req0_a;
                op_b_q       <= grant_id ? req1_b : req0_b;
                op_ctrl_q    <= grant_id ? req1_ctrl : req0_ctrl;
                op_id_q      <= grant_id;
            end
            if (state_q == StExec) begin
                rsp_result_q <= alu_out;
                rsp_zero_q   <= alu_zero;
                rsp_id_q     <= op_id_q;
            end
        end
    end

    alu_share_arbiter_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .a      (op_a_q),
        .b      (op_b_q),
        .ctrl   (op_ctrl_q),
        .alu_out(alu_out),
        .zero   (alu_zero)
    );

    // Outputs read as idle/zero while reset is held, even before the reset edge lands.
    assign rsp_valid  = (state_q == StResp) && !rst;
    assign busy       = (state_q != StIdle) && !rst;
    assign rsp_id     = rst ? 1'b0 : rsp_id_q;
    assign rsp_result = rst ? '0 : rsp_result_q;
    assign rsp_zero   = rst ? 1'b0 : rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: queued requesters, timing/arbitration model, checker.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
    logic [31:0] rsp_result;

    alu_share_arbiter #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_ctrl (req0_ctrl),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_ctrl (req1_ctrl),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_result(rsp_result),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [3:0] ctrl; logic [31:0] a; logic [31:0] b;} op_t;
    typedef struct packed {logic id; logic [31:0] res; logic zero;} rsp_t;

    op_t  q0[$], q1[$];
    rsp_t sb[$], rsp_log[$];
    int   grant_log[$];
    int   errors = 0, checks = 0;
    int   rr_mode = 0;
    bit   gap_en = 1'b0;

    // Model state: idle flag, cycles until the response shows, last winner of a grant.
    bit   m_idle = 1'b1, m_last = 1'b1, cur_idle, exp_v, e0, e1, g;
    int   m_cnt = 0;
    rsp_t last_rsp = '0;
    op_t  mon_op;

    function automatic op_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        op_t o;
        o.ctrl = c;
        o.a    = a;
        o.b    = b;
        return o;
    endfunction

    function automatic rsp_t model(input bit id, input op_t op);
        rsp_t r;
        bit   known = 1'b1;
        r.id = id;
        case (op.ctrl)
            4'h0: r.res = op.a & op.b;
            4'h1: r.res = op.a | op.b;
            4'h2: r.res = op.a + op.b;
            4'h6: r.res = op.a - op.b;
            4'h7: r.res = ($signed(op.a) < $signed(op.b)) ? 32'd1 : 32'd0;
            4'h8: r.res = (op.a != op.b) ? 32'd1 : 32'd0;
            default: begin
                r.res = op.a;
                known = 1'b0;
            end
        endcase
        r.zero = known && (r.res == 32'd0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t log_at(input int i);
        return (rsp_log.size() > i) ? rsp_log[i] : 'x;
    endfunction

    function automatic int grant_at(input int i);
        return (grant_log.size() > i) ? grant_log[i] : -1;
    endfunction

    // Checker: sampled on the falling edge, between active edges.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_result", rsp_result, 0);
            chk("rst_rsp_zero", rsp_zero, 0);
            m_idle = 1'b1;
            m_cnt = 0;
            m_last = 1'b1;
            sb.delete();
            last_rsp = '0;
        end else begin
            cur_idle = m_idle;
            if (!m_idle && m_cnt > 0) m_cnt--;
            exp_v = !m_idle && (m_cnt == 0);
            chk("busy", busy, !cur_idle);
            chk("rsp_valid", rsp_valid, exp_v);
            if (exp_v) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got rsp_valid with no queued op, required none");
                end else begin
                    chk("rsp_id", rsp_id, sb[0].id);
                    chk("rsp_result", rsp_result, sb[0].res);
                    chk("rsp_zero", rsp_zero, sb[0].zero);
                    if (rsp_ready) begin
                        last_rsp = sb.pop_front();
                        rsp_log.push_back(last_rsp);
                        m_idle = 1'b1;
                    end
                end
            end else begin
                chk("hold_rsp_id", rsp_id, last_rsp.id);
                chk("hold_rsp_result", rsp_result, last_rsp.res);
                chk("hold_rsp_zero", rsp_zero, last_rsp.zero);
            end
            e0 = 1'b0;
            e1 = 1'b0;
            g  = 1'b0;
            if (cur_idle && (req0_valid || req1_valid)) begin
                g  = (req0_valid && req1_valid) ? !m_last : req1_valid;
                e0 = !g;
                e1 = g;
            end
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            if (e0 || e1) begin
                mon_op = g ? mk(req1_ctrl, req1_a, req1_b) : mk(req0_ctrl, req0_a, req0_b);
                sb.push_back(model(g, mon_op));
                grant_log.push_back(int'(g));
                m_last = g;
                m_idle = 1'b0;
                m_cnt  = 2;
            end
        end
    end

    // Requesters: present queue heads, hold until accepted, junk payload while idle.
    initial begin
        bit f0, f1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_a = '0; req1_b = '0; req1_ctrl = '0;
        forever begin
            @(negedge clk);
            f0 = req0_valid && req0_ready;
            f1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (f0 && q0.size() > 0) void'(q0.pop_front());
            if (f1 && q1.size() > 0) void'(q1.pop_front());
            if (!req0_valid || f0) begin
                if (q0.size() > 0 && !(gap_en && $urandom_range(0, 2) == 0)) begin
                    req0_valid = 1'b1;
                    {req0_ctrl, req0_a, req0_b} = q0[0];
                end else begin
                    req0_valid = 1'b0;
                    {req0_ctrl, req0_a, req0_b} = {4'($urandom), $urandom, $urandom};
                end
            end
            if (!req1_valid || f1) begin
                if (q1.size() > 0 && !(gap_en && $urandom_range(0, 2) == 0)) begin
                    req1_valid = 1'b1;
                    {req1_ctrl, req1_a, req1_b} = q1[0];
                end else begin
                    req1_valid = 1'b0;
                    {req1_ctrl, req1_a, req1_b} = {4'($urandom), $urandom, $urandom};
                end
            end
        end
    end

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    task automatic drain(input string name);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || req0_valid || req1_valid || !m_idle ||
                sb.size() > 0) && n < 1000) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL drain_%s: got still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic logic [3:0] rand_ctrl();
        case ($urandom_range(0, 6))
            0: return 4'h0;
            1: return 4'h1;
            2: return 4'h2;
            3: return 4'h6;
            4: return 4'h7;
            5: return 4'h8;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        int   exp_g[6] = '{0, 1, 0, 1, 0, 1};
        int   n;
        op_t  o;
        rsp_t r;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single ADD from requester 0.
        rsp_log.delete();
        q0.push_back(mk(4'h2, 32'd5, 32'd7));
        drain("add");
        r = log_at(0);
        chk("add_result", r.res, 32'd12);
        chk("add_id", r.id, 0);
        chk("add_zero", r.zero, 0);

        // Tie straight after reset: requester 0 first.
        do_reset();
        rsp_log.delete();
        q0.push_back(mk(4'h6, 32'd9, 32'd9));
        q1.push_back(mk(4'h1, 32'hF0, 32'h0F));
        drain("tie");
        r = log_at(0);
        chk("tie0_id", r.id, 0);
        chk("tie0_result", r.res, 32'd0);
        chk("tie0_zero", r.zero, 1);
        r = log_at(1);
        chk("tie1_id", r.id, 1);
        chk("tie1_result", r.res, 32'hFF);

        // Continuous contention alternates grants.
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(rand_ctrl(), $urandom, $urandom));
            q1.push_back(mk(rand_ctrl(), $urandom, $urandom));
        end
        drain("rr");
        for (int i = 0; i < 6; i++) chk($sformatf("rr_grant%0d", i), grant_at(i), exp_g[i]);

        // Consumer stalls in RESP.
        rsp_log.delete();
        rr_mode = 2;
        q0.push_back(mk(4'h2, 32'd100, 32'd23));
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reached_resp", rsp_valid, 1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_busy", busy, 1);
            chk("stall_valid", rsp_valid, 1);
        end
        rr_mode = 0;
        drain("stall");
        chk("stall_result", log_at(0).res, 32'd123);

        // Wraparound ADD then SLT on requester 1.
        rsp_log.delete();
        q1.push_back(mk(4'h2, 32'hFFFF_FFFF, 32'd1));
        q1.push_back(mk(4'h7, 32'd3, 32'd5));
        drain("wrap");
        r = log_at(0);
        chk("wrap_result", r.res, 32'd0);
        chk("wrap_zero", r.zero, 1);
        chk("wrap_id", r.id, 1);
        chk("slt_result", log_at(1).res, 32'd1);

        // Reset while requester 0's op is in EXEC.
        rsp_log.delete();
        q0.push_back(mk(4'h2, 32'd1, 32'd2));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req0_valid && req0_ready) && n < 20);
        chk("exec_accept_seen", req0_valid && req0_ready, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("post_rst_busy", busy, 0);
        grant_log.delete();
        q0.push_back(mk(4'h0, 32'hFF00, 32'h0FF0));
        q1.push_back(mk(4'h8, 32'd4, 32'd4));
        drain("rst_exec");
        chk("rst_tie_grant", grant_at(0), 0);
        chk("rst_rsp_count", rsp_log.size(), 2);
        chk("rst_first_result", log_at(0).res, 32'h0F00);

        // Random traffic with random consumer back-pressure.
        rsp_log.delete();
        rr_mode = 1;
        gap_en  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            o.ctrl = rand_ctrl();
            o.a    = $urandom;
            o.b    = ($urandom_range(0, 3) == 0) ? o.a : $urandom;
            if ($urandom_range(0, 1) == 0) q0.push_back(o);
            else q1.push_back(o);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
        end
        drain("random");
        chk("random_rsp_count", rsp_log.size(), 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
